// File: rtl/pc_seq_pkg.sv
// Shared types for the fetch PC sequencer.
// Redirect sources listed lowest to highest priority.
package pc_seq_pkg;

    localparam int unsigned PC_W = 16;
    localparam logic [PC_W-1:0] RESET_PC = 16'h0000;

    typedef enum logic [2:0] {
        REDIR_SEQ,
        REDIR_BRANCH,
        REDIR_JUMP,
        REDIR_CALL,
        REDIR_RET
    } redir_e;

    // Priority pick: ret, call, jump, taken branch, then fall-through.
    function automatic redir_e redir_pick(
        input logic ret,
        input logic call,
        input logic jump,
        input logic br_taken
    );
        redir_e sel;
        if (ret)
            sel = REDIR_RET;
        else if (call)
            sel = REDIR_CALL;
        else if (jump)
            sel = REDIR_JUMP;
        else if (br_taken)
            sel = REDIR_BRANCH;
        else
            sel = REDIR_SEQ;
        return sel;
    endfunction

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack; a push when full overwrites the oldest.
// Popping an empty stack yields RESET_VAL and sets a sticky underflow flag.
module return_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W = 16,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] push_data_i,
    output logic [W-1:0] top_o,
    output logic         empty_o,
    output logic         full_o,
    output logic         underflow_o
);
    import pc_seq_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          empty_q;
    logic          full_q;
    logic          under_q;
    logic          under_d;

    // Next pointer/count; push and pop are never both set by the parent.
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        under_d = under_q;
        if (push_i) begin
            ptr_d = ptr_q + AW'(1);
            if (count_q != FULL_CNT)
                count_d = count_q + CW'(1);
        end else if (pop_i) begin
            if (count_q != '0) begin
                ptr_d   = ptr_q - AW'(1);
                count_d = count_q - CW'(1);
            end else begin
                under_d = 1'b1;
            end
        end
    end

    // Stack storage, pointer and status flags registered from next count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            under_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++)
                mem_q[i] <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == FULL_CNT);
            under_q <= under_d;
            if (push_i)
                mem_q[ptr_q] <= push_data_i;
        end
    end

    assign top_o = (count_q == '0) ? RESET_VAL : mem_q[ptr_q - AW'(1)];
    assign empty_o = empty_q;
    assign full_o = full_q;
    assign underflow_o = under_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: picks next PC and flushes the wrong-path fetch.
// Build option PC_RAS_EN adds a return-address stack for ret targets.
module pc_sequencer #(
    parameter int unsigned PC_W = pc_seq_pkg::PC_W,
    parameter int unsigned RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC = pc_seq_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [PC_W-1:0] id_pc,
    input  logic            branch_valid,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            jump_valid,
    input  logic            call_valid,
    input  logic [PC_W-1:0] jump_target,
    input  logic            ret_valid,
    input  logic [PC_W-1:0] ret_addr,
    output logic [PC_W-1:0] pc,
    output logic            flush,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_underflow
);
    import pc_seq_pkg::*;

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] ret_tgt;
    redir_e          sel;

    assign sel = redir_pick(ret_valid, call_valid, jump_valid,
                            branch_valid & branch_taken);

`ifdef PC_RAS_EN
    logic            ras_push;
    logic            ras_pop;
    logic [PC_W-1:0] ras_top;
    logic            unused_ret_addr;

    assign ras_push = (sel == REDIR_CALL) & ~stall;
    assign ras_pop  = (sel == REDIR_RET) & ~stall;
    assign ret_tgt  = ras_top;
    assign unused_ret_addr = ^ret_addr;

    return_stack #(
        .DEPTH     (RAS_DEPTH),
        .W         (PC_W),
        .RESET_VAL (RESET_PC)
    ) u_ras (
        .clk         (clk),
        .rst         (rst),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (id_pc + PC_W'(1)),
        .top_o       (ras_top),
        .empty_o     (ras_empty),
        .full_o      (ras_full),
        .underflow_o (ras_underflow)
    );
`else
    logic unused_id_pc;

    assign ret_tgt = ret_addr;
    assign ras_empty = 1'b1;
    assign ras_full = 1'b0;
    assign ras_underflow = 1'b0;
    assign unused_id_pc = ^id_pc;
`endif

    // Next-PC mux; a stall freezes the PC and suppresses the flush.
    always_comb begin
        pc_d  = pc_q + PC_W'(1);
        flush = 1'b0;
        unique case (sel)
            REDIR_RET:    pc_d = ret_tgt;
            REDIR_CALL:   pc_d = jump_target;
            REDIR_JUMP:   pc_d = jump_target;
            REDIR_BRANCH: pc_d = branch_target;
            default:      pc_d = pc_q + PC_W'(1);
        endcase
        if (stall)
            pc_d = pc_q;
        else if (!rst && sel != REDIR_SEQ)
            flush = 1'b1;
    end

    // Fetch PC register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_d;
    end

    assign pc = pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
// Expectations adapt to whether PC_RAS_EN is defined.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic [15:0] id_pc = '0;
    logic        branch_valid = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = '0;
    logic        jump_valid = 1'b0;
    logic        call_valid = 1'b0;
    logic [15:0] jump_target = '0;
    logic        ret_valid = 1'b0;
    logic [15:0] ret_addr = '0;
    logic [15:0] pc;
    logic        flush;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_underflow;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef PC_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    always #5 clk = ~clk;

    pc_sequencer #(
        .PC_W      (16),
        .RAS_DEPTH (4),
        .RESET_PC  (16'h0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .id_pc         (id_pc),
        .branch_valid  (branch_valid),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump_valid    (jump_valid),
        .call_valid    (call_valid),
        .jump_target   (jump_target),
        .ret_valid     (ret_valid),
        .ret_addr      (ret_addr),
        .pc            (pc),
        .flush         (flush),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_underflow (ras_underflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        stall = 1'b0;
        id_pc = '0;
        branch_valid = 1'b0;
        branch_taken = 1'b0;
        branch_target = '0;
        jump_valid = 1'b0;
        call_valid = 1'b0;
        jump_target = '0;
        ret_valid = 1'b0;
        ret_addr = '0;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_in();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (pc !== 16'h0000 || flush !== 1'b0 || ras_empty !== 1'b1 ||
            ras_full !== 1'b0 || ras_underflow !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: got pc=%h fl=%b e=%b f=%b u=%b want 0000 0 1 0 0",
                     pc, flush, ras_empty, ras_full, ras_underflow);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_cmp++;
            if (pc !== 16'(i) || flush !== 1'b0) begin
                n_bad++;
                $display("FAIL free_run%0d: got pc=%h fl=%b want %h 0",
                         i, pc, flush, 16'(i));
            end
        end
    endtask

    task automatic test_branch();
        do_reset();
        repeat (5) tick();
        branch_valid = 1'b1;
        branch_taken = 1'b1;
        branch_target = 16'h0040;
        #1;
        n_cmp++;
        if (pc !== 16'h0005 || flush !== 1'b1) begin
            n_bad++;
            $display("FAIL br_taken_flush: got pc=%h fl=%b want 0005 1", pc, flush);
        end
        tick();
        n_cmp++;
        if (pc !== 16'h0040) begin
            n_bad++;
            $display("FAIL br_taken_pc: got %h want 0040", pc);
        end
        branch_taken = 1'b0;
        #1;
        n_cmp++;
        if (flush !== 1'b0) begin
            n_bad++;
            $display("FAIL br_nt_flush: got %b want 0", flush);
        end
        tick();
        n_cmp++;
        if (pc !== 16'h0041) begin
            n_bad++;
            $display("FAIL br_nt_pc: got %h want 0041", pc);
        end
        clear_in();
    endtask

    task automatic test_call_ret();
        do_reset();
        id_pc = 16'h0010;
        call_valid = 1'b1;
        jump_target = 16'h0100;
        #1;
        n_cmp++;
        if (flush !== 1'b1 || ras_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL call_flush: got fl=%b e=%b want 1 1", flush, ras_empty);
        end
        tick();
        n_cmp++;
        if (pc !== 16'h0100 || ras_empty !== !RAS) begin
            n_bad++;
            $display("FAIL call_pc: got pc=%h e=%b want 0100 %b", pc, ras_empty, !RAS);
        end
        call_valid = 1'b0;
        ret_valid = 1'b1;
        ret_addr = 16'h0011;
        #1;
        n_cmp++;
        if (flush !== 1'b1) begin
            n_bad++;
            $display("FAIL ret_flush: got %b want 1", flush);
        end
        tick();
        n_cmp++;
        if (pc !== 16'h0011 || ras_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL ret_pc: got pc=%h e=%b want 0011 1", pc, ras_empty);
        end
        clear_in();
    endtask

    task automatic test_ras_overflow();
        logic [15:0] exp_t [5];
        exp_t[0] = 16'h0006;
        exp_t[1] = 16'h0005;
        exp_t[2] = 16'h0004;
        exp_t[3] = 16'h0003;
        exp_t[4] = 16'h0000;
        do_reset();
        call_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            id_pc = 16'(i);
            jump_target = 16'h0200 + 16'(i);
            tick();
        end
        n_cmp++;
        if (pc !== 16'h0205 || ras_full !== RAS || ras_empty !== !RAS) begin
            n_bad++;
            $display("FAIL ras_fill: got pc=%h f=%b e=%b want 0205 %b %b",
                     pc, ras_full, ras_empty, RAS, !RAS);
        end
        call_valid = 1'b0;
        ret_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ret_addr = exp_t[i];
            tick();
            n_cmp++;
            if (pc !== exp_t[i]) begin
                n_bad++;
                $display("FAIL ras_pop%0d: got %h want %h", i, pc, exp_t[i]);
            end
            if (i == 3) begin
                n_cmp++;
                if (ras_empty !== 1'b1 || ras_underflow !== 1'b0) begin
                    n_bad++;
                    $display("FAIL ras_drained: got e=%b u=%b want 1 0",
                             ras_empty, ras_underflow);
                end
            end
        end
        n_cmp++;
        if (ras_underflow !== RAS || ras_empty !== 1'b1 || ras_full !== 1'b0) begin
            n_bad++;
            $display("FAIL ras_underflow: got u=%b e=%b f=%b want %b 1 0",
                     ras_underflow, ras_empty, ras_full, RAS);
        end
        ret_valid = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (ras_underflow !== RAS) begin
            n_bad++;
            $display("FAIL underflow_sticky: got %b want %b", ras_underflow, RAS);
        end
        clear_in();
    endtask

    task automatic test_stall();
        do_reset();
        stall = 1'b1;
        jump_valid = 1'b1;
        jump_target = 16'h0077;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++;
            if (flush !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_flush%0d: got %b want 0", i, flush);
            end
            tick();
            n_cmp++;
            if (pc !== 16'h0000) begin
                n_bad++;
                $display("FAIL stall_pc%0d: got %h want 0000", i, pc);
            end
        end
        stall = 1'b0;
        #1;
        n_cmp++;
        if (flush !== 1'b1) begin
            n_bad++;
            $display("FAIL unstall_flush: got %b want 1", flush);
        end
        tick();
        n_cmp++;
        if (pc !== 16'h0077) begin
            n_bad++;
            $display("FAIL unstall_pc: got %h want 0077", pc);
        end
        clear_in();
    endtask

    task automatic test_back_to_back();
        do_reset();
        jump_valid = 1'b1;
        call_valid = 1'b1;
        ret_valid = 1'b1;
        branch_valid = 1'b1;
        branch_taken = 1'b1;
        branch_target = 16'h0123;
        jump_target = 16'h0456;
        ret_addr = 16'h0000;
        tick();
        n_cmp++;
        if (pc !== 16'h0000 || ras_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL prio_ret: got pc=%h e=%b want 0000 1", pc, ras_empty);
        end
        ret_valid = 1'b0;
        call_valid = 1'b0;
        tick();
        n_cmp++;
        if (pc !== 16'h0456) begin
            n_bad++;
            $display("FAIL prio_jump: got %h want 0456", pc);
        end
        clear_in();
    endtask

    task automatic test_wrap_and_async_reset();
        do_reset();
        jump_valid = 1'b1;
        jump_target = 16'hFFFF;
        tick();
        jump_valid = 1'b0;
        n_cmp++;
        if (pc !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL wrap_setup: got %h want ffff", pc);
        end
        tick();
        n_cmp++;
        if (pc !== 16'h0000) begin
            n_bad++;
            $display("FAIL wrap_pc: got %h want 0000", pc);
        end
        id_pc = 16'h0005;
        call_valid = 1'b1;
        jump_target = 16'h0030;
        tick();
        n_cmp++;
        if (pc !== 16'h0030 || ras_empty !== !RAS) begin
            n_bad++;
            $display("FAIL pre_rst_call: got pc=%h e=%b want 0030 %b", pc, ras_empty, !RAS);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (pc !== 16'h0000 || ras_empty !== 1'b1 || flush !== 1'b0) begin
            n_bad++;
            $display("FAIL async_rst: got pc=%h e=%b fl=%b want 0000 1 0",
                     pc, ras_empty, flush);
        end
        clear_in();
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_cmp++;
        if (pc !== 16'h0001) begin
            n_bad++;
            $display("FAIL post_rst_pc: got %h want 0001", pc);
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_call_ret();
        test_ras_overflow();
        test_stall();
        test_back_to_back();
        test_wrap_and_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the 16-bit RISC core, directly downstream of the branch comparator. Holds the fetch PC, consumes the comparator's branch-taken flag plus decode-stage jump/call/return requests, selects the next PC, and raises a one-cycle flush to kill the wrong-path fetch. Calls push return addresses onto a small return-address stack (RAS) that `ret` pops.

## Interface
Parameters:
- `PC_W`, 16: PC and target width; word-addressed.
- `RAS_DEPTH`, 4: return-stack entries; power of two, ≥2.
- `RESET_PC`, 16'h0000: PC after reset.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset: asynchronous, active-high.
- `stall`  in  1  hazard stall; PC, RAS and redirect logic hold.
- `id_pc`  in  PC_W  PC of the instruction currently in decode.
- `branch_valid`  in  1  decode holds a conditional branch (opcodes 1000–1111).
- `branch_taken`  in  1  comparator `zero` output; used only with `branch_valid`.
- `branch_target`  in  PC_W  branch destination.
- `jump_valid`  in  1  unconditional jump.
- `call_valid`  in  1  call: jump to `jump_target` and push `id_pc+1`.
- `jump_target`  in  PC_W  jump/call destination.
- `ret_valid`  in  1  return.
- `ret_addr`  in  PC_W  register-sourced return address; used only without `PC_RAS_EN`.
- `pc`  out  PC_W  fetch PC (registered).
- `flush`  out  1  kill the instruction in fetch this cycle.
- `ras_empty`  out  1  stack holds no entries.
- `ras_full`  out  1  stack holds `RAS_DEPTH` entries.
- `ras_underflow`  out  1  sticky: `ret` popped an empty stack.

## Operation
- Redirect priority (highest first): `ret_valid` → `call_valid` → `jump_valid` → `branch_valid & branch_taken` → sequential `pc+1`.
- Next PC per source: RET = RAS top (or `ret_addr`); CALL/JUMP = `jump_target`; BRANCH = `branch_target`; sequential = `pc+1`, wrapping 16'hFFFF → 16'h0000.
- `flush` = any redirect selected & !stall & !rst; combinational. Not-taken branch: no flush.
- `stall`=1: `pc` holds, no push/pop, `flush`=0; requests are re-evaluated once the stall drops (decode holds its inputs).
- Call: push `id_pc+1` (mod 2^PC_W). Push on full overwrites the oldest entry (circular); `ras_full` stays 1.
- Ret: pop top. Pop on empty: target = `RESET_PC`, `ras_underflow` set, count stays 0.
- `call_valid` and `ret_valid` together: RET wins, no push, pop only.
- Multiple request bits in one cycle are legal; only the highest-priority one acts.

## Timing
- Reset values: `pc`=`RESET_PC`, `flush`=0, `ras_empty`=1, `ras_full`=0, `ras_underflow`=0, stack count 0.
- Reset mid-operation clears the PC and RAS asynchronously; the first edge after deassertion fetches `RESET_PC+1`.
- Redirect latency: request seen in cycle N → `pc` = target in cycle N+1; `flush` high in cycle N only.
- Push/pop take effect at the same edge as the PC update; a call immediately followed by a ret returns the pushed address with no bubble.
- `ras_empty`/`ras_full` are registered from count; `ras_underflow` clears only on `rst`.

## Configuration
- `PC_RAS_EN` defined: RAS built as described; `ret_addr` ignored.
- Undefined: no stack; RET target = `ret_addr`; `ras_empty`=1, `ras_full`=0, `ras_underflow`=0 constantly; call performs the jump only.

## Structure
- Package `pc_seq_pkg`: `PC_W`, `RESET_PC`, redirect-source enum (`REDIR_SEQ`, `REDIR_BRANCH`, `REDIR_JUMP`, `REDIR_CALL`, `REDIR_RET`).
- Sub-module `return_stack` (circular buffer, count, push/pop, full/empty/underflow), instantiated only under `PC_RAS_EN`.

## Test plan
- Reset then 3 free-running cycles → `pc` = 0000, 0001, 0002, 0003; `flush`=0 throughout.
- `branch_valid`=1, `branch_taken`=1, `branch_target`=0040 at pc=0005 → `flush`=1 that cycle, next `pc`=0040; same with `branch_taken`=0 → `pc`=0006, no flush.
- Call at `id_pc`=0010 to 0100, then ret → `pc`=0100, then 0011; `ras_empty` 1→0→1.
- Five calls with `RAS_DEPTH`=4 (id_pc 1,2,3,4,5), four rets → targets 0006, 0005, 0004, 0003; fifth ret → `pc`=0000, `ras_underflow`=1.
- `stall`=1 with `jump_valid`=1 for 2 cycles → `pc` frozen, `flush`=0; stall drops → `flush`=1, `pc`=`jump_target` next cycle.
- pc=FFFF sequential → 0000; assert `rst` mid-call-sequence → `pc`=0000, `ras_empty`=1 immediately without a clock edge.
